boolean_expression: RTL and testbench
=====================================

// Module: boolean_expression
// PURPOSE
//  16-to-4 priority encoder: reports the index of the highest-numbered asserted bit of D.
//  Combinational encode (Y, V) for zero-latency use, plus a registered copy (Y_q, V_q) for pipelined consumers.
//  Intended as a request-arbitration / interrupt-priority front end; D[15] has highest priority.
// PARAMETERS
//  none -- width fixed at 16 inputs / 4-bit index (constants in package, see STRUCTURE)
// PORTS
//  clk    input   1   sole clock; all state updates on rising edge
//  rst    input   1   reset, synchronous, active-high
//  D      input   16  request vector; D[15] highest priority, D[0] lowest
//  Y      output  4   combinational index of highest set bit of D
//  V      output  1   combinational valid: 1 when D != 0
//  Y_q    output  4   Y registered on clk
//  V_q    output  1   V registered on clk
//  G      output  16  one-hot grant (only with BOOLEAN_EXPRESSION_ONEHOT_EN)
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high (rst).
//  - Y = max i such that D[i]==1; lower set bits are ignored.
//  - D == 16'h0000: Y = 4'd0, V = 0 (Y=0 with V=0 is distinguishable from D==16'h0001: Y=0, V=1).
//  - Y, V purely combinational from D: no clock dependence, settle within same delta/cycle; no latches.
//  - Y_q/V_q: at each rising clk, rst=1 -> Y_q=4'd0, V_q=0; else Y_q<=Y, V_q<=V. Latency 1 cycle.
//  - rst asserted mid-operation clears Y_q/V_q at next edge only; Y/V keep tracking D during reset.
//  - No handshake; D sampled every cycle. X on D must not be masked (propagates to outputs in sim).
// CONFIGURATION
//  - Macro BOOLEAN_EXPRESSION_ONEHOT_EN:
//    defined  -> port G present; G = V ? (16'h1 << Y) : 16'h0000, combinational (no register).
//    undefined-> port G absent; all other behaviour identical.
// STRUCTURE
//  - Package boolean_expression_pkg: localparam D_W=16, Y_W=4; typedef logic [D_W-1:0] req_t;
//    typedef logic [Y_W-1:0] idx_t.
//  - Sub-module prio_enc16: combinational core (D -> Y, V), e.g. two-level 4x4 group encode:
//    group-any per nibble, select highest nonzero nibble (Y[3:2]), encode within it (Y[1:0]).
//  - Top: instantiates prio_enc16, output register for Y_q/V_q, optional one-hot decode.
// TESTING
//  - D=16'h0000 -> Y=0, V=0; after clk, Y_q=0, V_q=0.
//  - D=16'hFFFF -> Y=15, V=1; D=16'h000F -> Y=3; D=16'h0001 -> Y=0, V=1.
//  - D=16'h1111 -> Y=12; D=16'h7FFE -> Y=14; D=16'h01FE -> Y=8; D=16'h8001 -> Y=15.
//  - Pipeline: D=16'h0F0F then 16'h0000 on successive edges -> Y_q=11,V_q=1 then Y_q=0,V_q=0.
//  - rst=1 while D=16'hFFFF -> Y_q=0,V_q=0 at next edge, Y=15 meanwhile; release -> Y_q=15.
//  - With BOOLEAN_EXPRESSION_ONEHOT_EN: D=16'h0600 -> G=16'h0400; D=0 -> G=0; sweep all 16 one-hot D.

Source files
------------

// File: rtl/boolean_expression_pkg.sv
// boolean_expression_pkg: widths and request/index types shared by the priority encoder
package boolean_expression_pkg;
    localparam int D_W = 16;
    localparam int Y_W = 4;
    typedef logic [D_W-1:0] req_t;
    typedef logic [Y_W-1:0] idx_t;
endpackage

// File: rtl/boolean_expression_prio_enc16.sv
// prio_enc16: combinational 16-to-4 priority encoder, highest set bit wins, two-level nibble encode
module prio_enc16
    import boolean_expression_pkg::*;
(
    input  logic [D_W-1:0] D,
    output logic [Y_W-1:0] Y,
    output logic           V
);
    logic [3:0] grp;
    logic [1:0] hi;
    logic [1:0] lo;
    logic [3:0] nib;
    // pick the highest non-empty nibble, then the highest bit inside it; ternaries keep X visible in sim
    always_comb begin
        grp = {|D[15:12], |D[11:8], |D[7:4], |D[3:0]};
        hi  = grp[3] ? 2'd3 : grp[2] ? 2'd2 : grp[1] ? 2'd1 : 2'd0;
        nib = D[{hi, 2'b00} +: 4];
        lo  = nib[3] ? 2'd3 : nib[2] ? 2'd2 : nib[1] ? 2'd1 : 2'd0;
        Y   = {hi, lo};
        V   = |grp;
    end
endmodule

// File: rtl/boolean_expression.sv
// boolean_expression: priority encoder with combinational and registered index; one-hot grant G under BOOLEAN_EXPRESSION_ONEHOT_EN
module boolean_expression
    import boolean_expression_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic [D_W-1:0] D,
    output logic [Y_W-1:0] Y,
    output logic           V,
    output logic [Y_W-1:0] Y_q,
    output logic           V_q
`ifdef BOOLEAN_EXPRESSION_ONEHOT_EN
    ,
    output logic [D_W-1:0] G
`endif
);
    prio_enc16 u_enc (
        .D(D),
        .Y(Y),
        .V(V)
    );
    // one-cycle registered copy for pipelined consumers; reset clears only this copy
    always_ff @(posedge clk) begin
        Y_q <= rst ? '0 : Y;
        V_q <= rst ? 1'b0 : V;
    end
`ifdef BOOLEAN_EXPRESSION_ONEHOT_EN
    assign G = V ? (req_t'(1) << Y) : '0;
`endif
endmodule

// File: tb/tb_boolean_expression.sv
// tb_boolean_expression: directed-vector self-checking bench for boolean_expression
module tb_boolean_expression;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] D;
    logic [3:0]  Y;
    logic        V;
    logic [3:0]  Y_q;
    logic        V_q;
`ifdef BOOLEAN_EXPRESSION_ONEHOT_EN
    logic [15:0] G;
`endif
    int checks = 0;
    int passes = 0;

    boolean_expression dut (
        .clk(clk),
        .rst(rst),
        .D(D),
        .Y(Y),
        .V(V),
        .Y_q(Y_q),
        .V_q(V_q)
`ifdef BOOLEAN_EXPRESSION_ONEHOT_EN
        ,
        .G(G)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    typedef struct {
        logic [15:0] d;
        logic [3:0]  y;
        logic        v;
    } vec_t;

    vec_t vecs[10] = '{
        '{16'h0000, 4'd0,  1'b0},
        '{16'hFFFF, 4'd15, 1'b1},
        '{16'h000F, 4'd3,  1'b1},
        '{16'h0001, 4'd0,  1'b1},
        '{16'h1111, 4'd12, 1'b1},
        '{16'h7FFE, 4'd14, 1'b1},
        '{16'h01FE, 4'd8,  1'b1},
        '{16'h8001, 4'd15, 1'b1},
        '{16'h0600, 4'd10, 1'b1},
        '{16'h0F0F, 4'd11, 1'b1}
    };

    initial begin
        rst = 1'b1;
        D   = 16'h0000;
        @(posedge clk);
        #1;
        check("reset_Y_q", 16'(Y_q), 16'd0);
        check("reset_V_q", 16'(V_q), 16'd0);
        rst = 1'b0;
        foreach (vecs[i]) begin
            D = vecs[i].d;
            #1;
            check($sformatf("Y[%h]", vecs[i].d), 16'(Y), 16'(vecs[i].y));
            check($sformatf("V[%h]", vecs[i].d), 16'(V), 16'(vecs[i].v));
`ifdef BOOLEAN_EXPRESSION_ONEHOT_EN
            check($sformatf("G[%h]", vecs[i].d), G, vecs[i].v ? (16'h1 << vecs[i].y) : 16'h0);
`endif
            @(posedge clk);
            #1;
            check($sformatf("Y_q[%h]", vecs[i].d), 16'(Y_q), 16'(vecs[i].y));
            check($sformatf("V_q[%h]", vecs[i].d), 16'(V_q), 16'(vecs[i].v));
        end
        D = 16'h0F0F;
        @(posedge clk);
        #1;
        D = 16'h0000;
        check("pipe_Y_q_a", 16'(Y_q), 16'd11);
        check("pipe_V_q_a", 16'(V_q), 16'd1);
        @(posedge clk);
        #1;
        check("pipe_Y_q_b", 16'(Y_q), 16'd0);
        check("pipe_V_q_b", 16'(V_q), 16'd0);
        D = 16'hFFFF;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_Y_q", 16'(Y_q), 16'd0);
        check("rst_V_q", 16'(V_q), 16'd0);
        check("rst_Y", 16'(Y), 16'd15);
        check("rst_V", 16'(V), 16'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rel_Y_q", 16'(Y_q), 16'd15);
        check("rel_V_q", 16'(V_q), 16'd1);
        for (int i = 0; i < 16; i++) begin
            D = 16'h1 << i;
            #1;
            check($sformatf("sweep_Y[%0d]", i), 16'(Y), 16'(i));
            check($sformatf("sweep_V[%0d]", i), 16'(V), 16'd1);
`ifdef BOOLEAN_EXPRESSION_ONEHOT_EN
            check($sformatf("sweep_G[%0d]", i), G, 16'h1 << i);
`endif
            #4;
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
